// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES block loader.
package aes_pkg;

  localparam int unsigned AES_WORDS = 4;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic {IDLE, RUN} loader_state_e;

  function automatic aes_word_t byteswap32(input aes_word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_word_bank.sv
// Four-word register file assembling a 128-bit block, word 0 in bits [127:96],
// with a per-word valid mask.
module aes_word_bank
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_idx,
  input  aes_word_t  wr_data,
  input  logic       clr_mask,
  output aes_block_t block,
  output logic [3:0] mask
);

  aes_word_t words [AES_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      words <= '{default: '0};
      mask  <= '0;
    end else begin
      if (clr_mask) mask <= '0;
      if (wr_en) begin
        words[wr_idx] <= wr_data;
        mask[wr_idx]  <= 1'b1;
      end
    end
  end

  assign block = {words[0], words[1], words[2], words[3]};

endmodule

// File: rtl/aes_block_loader.sv
// Word-wide front end for aescipher: assembles plaintext/key, holds them for the
// cipher latency, captures the result. Optional macro: AES_LOADER_BYTESWAP_EN.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int unsigned CIPHER_LAT = 10,
  parameter int unsigned WORD_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [1:0]        wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              start,
  input  logic [1:0]        rd_idx,
  output logic [WORD_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic              err,
  output logic [127:0]      cipher_datain,
  output logic [127:0]      cipher_key,
  input  logic [127:0]      cipher_dataout
);

  localparam int unsigned CNT_W = $clog2(CIPHER_LAT + 1);

  loader_state_e state, next_state;
  logic [CNT_W-1:0] cnt;
  aes_block_t result;
  aes_word_t  wr_word, rd_word;
  logic [3:0] data_mask, key_mask;
  logic [6:0] rd_base;
  logic launch, finish, err_set, data_we, key_we;

`ifdef AES_LOADER_BYTESWAP_EN
  assign wr_word = byteswap32(wr_data);
`else
  assign wr_word = wr_data;
`endif

  // Writes are only accepted in IDLE; masks seen by the FSM are the pre-write values.
  assign data_we = wr_en && (state == IDLE) && !wr_sel;
  assign key_we  = wr_en && (state == IDLE) &&  wr_sel;

  aes_word_bank u_data_bank (
    .clk(clk), .rst(rst), .wr_en(data_we), .wr_idx(wr_idx), .wr_data(wr_word),
    .clr_mask(finish), .block(cipher_datain), .mask(data_mask)
  );

  aes_word_bank u_key_bank (
    .clk(clk), .rst(rst), .wr_en(key_we), .wr_idx(wr_idx), .wr_data(wr_word),
    .clr_mask(1'b0), .block(cipher_key), .mask(key_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    launch     = 1'b0;
    finish     = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if ((&data_mask) && (&key_mask)) begin
            launch     = 1'b1;
            next_state = RUN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      RUN: begin
        if (wr_en) err_set = 1'b1;
        if (cnt == CNT_W'(CIPHER_LAT)) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Word 0 lives in the top bits, so the base offset is 32*(3-rd_idx).
  assign rd_base = {~rd_idx, 5'b0};
  assign rd_word = result[rd_base +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      result       <= '0;
      rd_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= finish;
      if (launch) begin
        busy         <= 1'b1;
        cnt          <= '0;
        result_valid <= 1'b0;
      end
      if (state == RUN && !finish) cnt <= cnt + 1'b1;
      if (finish) begin
        result       <= cipher_dataout;
        result_valid <= 1'b1;
        busy         <= 1'b0;
      end
      if (err_set) err <= 1'b1;
`ifdef AES_LOADER_BYTESWAP_EN
      rd_data <= byteswap32(rd_word);
`else
      rd_data <= rd_word;
`endif
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader with a 10-stage cipher stand-in that
// returns the FIPS-197 C.1 ciphertext for the C.1 inputs.
module tb_aes_block_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [1:0]   wr_idx = '0, rd_idx = '0;
  logic [31:0]  wr_data = '0, rd_data;
  logic         busy, done, result_valid, err;
  logic [127:0] cipher_datain, cipher_key, cipher_dataout;

  int tests = 0;
  int fails = 0;
  int lat;
  int done_cnt;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2  = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] P3  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  aes_block_loader #(.CIPHER_LAT(10), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx),
    .wr_data(wr_data), .start(start), .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .done(done), .result_valid(result_valid), .err(err),
    .cipher_datain(cipher_datain), .cipher_key(cipher_key),
    .cipher_dataout(cipher_dataout)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] model_f(input logic [127:0] d, input logic [127:0] k);
    if (d == P1 && k == K1) return CT1;
    return d ^ {k[63:0], k[127:64]} ^ 128'ha5a5a5a5_3c3c3c3c_0ff00ff0_12345678;
  endfunction

  function automatic logic [31:0] bs(input logic [31:0] w);
`ifdef AES_LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  logic [127:0] pipe [10];
  always @(posedge clk) begin
    pipe[0] <= model_f(cipher_datain, cipher_key);
    for (int i = 1; i < 10; i++) pipe[i] <= pipe[i-1];
  end
  assign cipher_dataout = pipe[9];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [1:0] idx, input logic [31:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_idx = idx; wr_data = bs(d);
    tick;
    wr_en = 1'b0;
  endtask

  task automatic load(input logic sel, input logic [127:0] blk, input int nwords);
    logic [127:0] b;
    b = blk;
    for (int i = 0; i < nwords; i++) wr(sel, 2'(i), b[127-32*i -: 32]);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (done) begin
        lat = i;
        break;
      end
    end
    check(tag, 128'(lat), 128'(exp_lat));
  endtask

  task automatic check_result(input string tag, input logic [127:0] blk);
    logic [127:0] b;
    b = blk;
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      tick;
      check(tag, 128'(rd_data), 128'(bs(b[127-32*i -: 32])));
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    do_reset;
    check("rst_busy", 128'(busy), 0);
    check("rst_done", 128'(done), 0);
    check("rst_rv", 128'(result_valid), 0);
    check("rst_err", 128'(err), 0);
    check("rst_rd", 128'(rd_data), 0);
    check("rst_din", cipher_datain, 0);

    // FIPS-197 C.1
    load(1'b1, K1, 4);
    load(1'b0, P1, 4);
    check("c1_key", cipher_key, K1);
    check("c1_din", cipher_datain, P1);
    pulse_start;
    check("c1_busy", 128'(busy), 1);
    wait_done("c1_latency", 11);
    check("c1_done_busy", 128'(busy), 0);
    check("c1_rv", 128'(result_valid), 1);
    tick;
    check("c1_done_pulse", 128'(done), 0);
    check_result("c1_rd", CT1);
    check("c1_err", 128'(err), 0);

    // Key retained, new plaintext
    load(1'b0, P2, 4);
    pulse_start;
    check("p2_rv_clr", 128'(result_valid), 0);
    wait_done("p2_latency", 11);
    check_result("p2_rd", model_f(P2, K1));
    check("p2_din_hold", cipher_datain, P2);

    // Plaintext mask cleared after completion
    pulse_start;
    check("remask_err", 128'(err), 1);
    check("remask_busy", 128'(busy), 0);

    // Only plaintext written after reset
    do_reset;
    load(1'b0, P1, 4);
    pulse_start;
    check("nokey_err", 128'(err), 1);
    check("nokey_busy", 128'(busy), 0);

    // Three of four plaintext words
    do_reset;
    load(1'b1, K1, 4);
    load(1'b0, P3, 3);
    pulse_start;
    check("3w_err", 128'(err), 1);
    check("3w_busy", 128'(busy), 0);
    wr(1'b0, 2'd3, P3[31:0]);
    pulse_start;
    check("4w_busy", 128'(busy), 1);
    wait_done("4w_latency", 11);
    check_result("4w_rd", model_f(P3, K1));

    // Write during RUN is rejected
    do_reset;
    load(1'b1, K1, 4);
    load(1'b0, P1, 4);
    pulse_start;
    tick;
    tick;
    wr(1'b0, 2'd0, 32'hcafef00d);
    check("runwr_err", 128'(err), 1);
    check("runwr_din", cipher_datain, P1);
    wait_done("runwr_latency", 8);
    check_result("runwr_rd", CT1);

    // Start in the same cycle as the completing write
    do_reset;
    load(1'b1, K1, 4);
    load(1'b0, P1, 3);
    wr_en = 1'b1; wr_sel = 1'b0; wr_idx = 2'd3; wr_data = bs(P1[31:0]); start = 1'b1;
    tick;
    wr_en = 1'b0; start = 1'b0;
    check("same_busy", 128'(busy), 0);
    check("same_err", 128'(err), 1);
    pulse_start;
    check("next_busy", 128'(busy), 1);
    wait_done("next_latency", 11);
    check_result("next_rd", CT1);

    // Reset in the middle of RUN
    load(1'b0, P1, 4);
    pulse_start;
    for (int i = 0; i < 4; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_busy", 128'(busy), 0);
    check("abort_rv", 128'(result_valid), 0);
    check("abort_err", 128'(err), 0);
    done_cnt = 0;
    rd_idx = 2'd0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (done) done_cnt++;
    end
    check("abort_no_done", 128'(done_cnt), 0);
    check("abort_rd", 128'(rd_data), 0);
    check("abort_busy_late", 128'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
